// File: rtl/board_ctrl.sv
// Tic-tac-toe board owner: serialises move/clear requests onto the action RAM,
// checks cell occupancy, writes the mark, rescans the board and reports win/draw.
module board_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        move_valid,
  output logic        move_ready,
  input  logic [3:0]  move_cell,
  input  logic        move_player,
  input  logic        clear_req,
  output logic        resp_valid,
  output logic [1:0]  resp_status,
  output logic        resp_win,
  output logic        resp_draw,
  output logic        game_over,
  output logic [7:0]  ram_write_address,
  output logic [15:0] ram_d_in,
  output logic        ram_write_enable,
  output logic [7:0]  ram_read_address,
  input  logic [15:0] ram_d_out
);

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 4;
  localparam int unsigned CELLS = 9;
  localparam int unsigned LAST  = 8;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_OCC = 2'b01;
  localparam logic [1:0] ST_ILL = 2'b10;
  localparam logic [1:0] ST_CLR = 2'b11;

  localparam logic [DW-1:0] CODE_X = 16'h0001;
  localparam logic [DW-1:0] CODE_O = 16'h0002;

  typedef enum logic [2:0] {
    IDLE, RD_CELL, CHK_CELL, WR_CELL, SCAN, EVAL, CLEAR, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cell_q, cell_d;
  logic            player_q, player_d;
  logic [DW-1:0]   shadow_q [CELLS];
  logic [DW-1:0]   shadow_d [CELLS];
  logic [DW-1:0]   board    [CELLS];
  logic [DW-1:0]   mover;
  logic            win, full;

  logic            ready_d, rv_d, rw_d, rd_d, go_d, we_d;
  logic [1:0]      rs_d;
  logic [AW-1:0]   wa_d, ra_d;
  logic [DW-1:0]   din_d;

  function automatic logic tri_eq(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [DW-1:0] c, input logic [DW-1:0] m);
    return (a == m) && (b == m) && (c == m);
  endfunction

  // In EVAL the last cell arrives straight from the RAM, alongside its capture.
  always_comb begin
    for (int i = 0; i < int'(CELLS); i++) board[i] = shadow_q[i];
    board[LAST] = ram_d_out;
    mover = player_q ? CODE_O : CODE_X;
    full = 1'b1;
    for (int i = 0; i < int'(CELLS); i++) if (board[i] == '0) full = 1'b0;
    win = tri_eq(board[0], board[1], board[2], mover) |
          tri_eq(board[3], board[4], board[5], mover) |
          tri_eq(board[6], board[7], board[8], mover) |
          tri_eq(board[0], board[3], board[6], mover) |
          tri_eq(board[1], board[4], board[7], mover) |
          tri_eq(board[2], board[5], board[8], mover) |
          tri_eq(board[0], board[4], board[8], mover) |
          tri_eq(board[2], board[4], board[6], mover);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      cell_q            <= '0;
      player_q          <= 1'b0;
      for (int i = 0; i < int'(CELLS); i++) shadow_q[i] <= '0;
      move_ready        <= 1'b1;
      resp_valid        <= 1'b0;
      resp_status       <= '0;
      resp_win          <= 1'b0;
      resp_draw         <= 1'b0;
      game_over         <= 1'b0;
      ram_write_address <= '0;
      ram_d_in          <= '0;
      ram_write_enable  <= 1'b0;
      ram_read_address  <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      cell_q            <= cell_d;
      player_q          <= player_d;
      for (int i = 0; i < int'(CELLS); i++) shadow_q[i] <= shadow_d[i];
      move_ready        <= ready_d;
      resp_valid        <= rv_d;
      resp_status       <= rs_d;
      resp_win          <= rw_d;
      resp_draw         <= rd_d;
      game_over         <= go_d;
      ram_write_address <= wa_d;
      ram_d_in          <= din_d;
      ram_write_enable  <= we_d;
      ram_read_address  <= ra_d;
    end
  end

  // Next state plus registered outputs, decoded from the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cell_d   = cell_q;
    player_d = player_q;
    for (int i = 0; i < int'(CELLS); i++) shadow_d[i] = shadow_q[i];
    go_d     = game_over;
    rv_d     = 1'b0;
    rs_d     = ST_OK;
    rw_d     = 1'b0;
    rd_d     = 1'b0;
    ready_d  = 1'b0;
    we_d     = 1'b0;
    wa_d     = '0;
    din_d    = '0;
    ra_d     = '0;

    case (state_q)
      IDLE: begin
        if (clear_req || move_valid) begin
          cell_d   = move_cell;
          player_d = move_player;
          if (clear_req) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end else if (move_cell > CW'(LAST) || game_over) begin
            state_d = DONE;
            rv_d    = 1'b1;
            rs_d    = ST_ILL;
          end else begin
            state_d = RD_CELL;
          end
        end
      end
      RD_CELL: state_d = CHK_CELL;
      CHK_CELL: begin
        if (ram_d_out != '0) begin
          state_d = DONE;
          rv_d    = 1'b1;
          rs_d    = ST_OCC;
        end else begin
          state_d = WR_CELL;
        end
      end
      WR_CELL: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
      SCAN: begin
        if (cnt_q != '0) shadow_d[cnt_q - CW'(1)] = ram_d_out;
        if (cnt_q == CW'(LAST)) state_d = EVAL;
        else                    cnt_d   = cnt_q + CW'(1);
      end
      EVAL: begin
        shadow_d[LAST] = ram_d_out;
        state_d = DONE;
        rv_d    = 1'b1;
        rs_d    = ST_OK;
        rw_d    = win;
        rd_d    = !win && full;
        go_d    = game_over | win | full;
      end
      CLEAR: begin
        if (cnt_q == CW'(LAST)) begin
          state_d = DONE;
          rv_d    = 1'b1;
          rs_d    = ST_CLR;
          go_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE:    ready_d = 1'b1;
      RD_CELL: ra_d = BASE_ADDR + AW'(cell_d);
      WR_CELL: begin
        we_d  = 1'b1;
        wa_d  = BASE_ADDR + AW'(cell_d);
        din_d = player_d ? CODE_O : CODE_X;
      end
      SCAN:    ra_d = BASE_ADDR + AW'(cnt_d);
      CLEAR: begin
        we_d = 1'b1;
        wa_d = BASE_ADDR + AW'(cnt_d);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl: a plain-array game model predicts each response,
// a negedge monitor checks responses, latency and write counts; RAM is modelled here.
module tb_board_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        move_valid = 1'b0;
  logic        move_ready;
  logic [3:0]  move_cell = 4'd0;
  logic        move_player = 1'b0;
  logic        clear_req = 1'b0;
  logic        resp_valid;
  logic [1:0]  resp_status;
  logic        resp_win, resp_draw, game_over;
  logic [7:0]  ram_write_address, ram_read_address;
  logic [15:0] ram_d_in, ram_d_out;
  logic        ram_write_enable;

  board_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_cell(move_cell), .move_player(move_player), .clear_req(clear_req),
    .resp_valid(resp_valid), .resp_status(resp_status),
    .resp_win(resp_win), .resp_draw(resp_draw), .game_over(game_over),
    .ram_write_address(ram_write_address), .ram_d_in(ram_d_in),
    .ram_write_enable(ram_write_enable), .ram_read_address(ram_read_address),
    .ram_d_out(ram_d_out)
  );

  always #5 clock = ~clock;

  // Action RAM: registered read, write on rising edge, untouched by reset.
  logic [15:0] mem [256];
  bit          ram_init = 1'b0;
  always @(posedge clock) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      ram_init <= 1'b1;
    end else if (ram_write_enable) begin
      mem[ram_write_address] <= ram_d_in;
    end
    ram_d_out <= mem[ram_read_address];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; int lat; int st; bit win; bit draw; bit go; int nw; } exp_t;
  exp_t q[$];
  int   ncmp = 0;
  int   nerr = 0;

  int model_board [9];
  bit model_go = 1'b0;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic check(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: counts write cycles and pops one expectation per response pulse.
  int wr_cnt = 0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      wr_cnt = 0;
    end else begin
      if (ram_write_enable) wr_cnt++;
      if (resp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = q.pop_front();
          check("resp_cycle", cyc, e.cyc);
          check("resp_status", int'(resp_status), e.st);
          check("resp_win", int'(resp_win), int'(e.win));
          check("resp_draw", int'(resp_draw), int'(e.draw));
          check("game_over", int'(game_over), int'(e.go));
          check("write_cycles", wr_cnt, e.nw);
        end
        wr_cnt = 0;
      end
    end
  end

  task automatic model(input bit clr, input int c, input bit p, output exp_t e);
    int code;
    bit w, full;
    code = p ? 2 : 1;
    e.win = 1'b0; e.draw = 1'b0; e.cyc = 0;
    if (clr) begin
      for (int i = 0; i < 9; i++) model_board[i] = 0;
      model_go = 1'b0; e.st = 3; e.lat = 10; e.nw = 9;
    end else if (c > 8 || model_go) begin
      e.st = 2; e.lat = 1; e.nw = 0;
    end else if (model_board[c] != 0) begin
      e.st = 1; e.lat = 3; e.nw = 0;
    end else begin
      model_board[c] = code;
      w = 1'b0;
      foreach (lines[l])
        if (model_board[lines[l][0]] == code && model_board[lines[l][1]] == code &&
            model_board[lines[l][2]] == code) w = 1'b1;
      full = 1'b1;
      for (int i = 0; i < 9; i++) if (model_board[i] == 0) full = 1'b0;
      e.win = w; e.draw = !w && full;
      model_go = w || full;
      e.st = 0; e.lat = 14; e.nw = 1;
    end
    e.go = model_go;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (move_ready) ok = 1'b1;
      else begin @(posedge clock); #1; end
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic check_ram();
    for (int i = 0; i < 9; i++) check($sformatf("ram_cell%0d", i), int'(mem[i]), model_board[i]);
  endtask

  task automatic do_req(input bit clr, input bit mv, input int c, input bit p);
    exp_t e;
    int   hs;
    wait_ready();
    clear_req = clr; move_valid = mv; move_cell = 4'(c); move_player = p;
    @(posedge clock); #1;
    hs = cyc;
    clear_req = 1'b0; move_valid = 1'b0;
    model(clr, c, p, e);
    e.cyc = hs + e.lat - 1;
    q.push_back(e);
    wait_ready();
    check_ram();
  endtask

  initial begin
    for (int i = 0; i < 9; i++) model_board[i] = 0;
    #12;
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_status", int'(resp_status), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_we", int'(ram_write_enable), 0);
    check("rst_addr_data", int'(ram_write_address) + int'(ram_read_address) + int'(ram_d_in), 0);
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_move_ready", int'(move_ready), 1);

    do_req(0, 1, 4, 0);          // X to centre
    do_req(0, 1, 4, 1);          // O to occupied centre
    do_req(0, 1, 9, 0);          // out-of-range cell
    do_req(1, 0, 0, 0);
    do_req(0, 1, 0, 0); do_req(0, 1, 3, 1); do_req(0, 1, 1, 0);
    do_req(0, 1, 4, 1); do_req(0, 1, 2, 0);      // X wins top row
    do_req(0, 1, 5, 1);                          // rejected after game over
    do_req(1, 0, 0, 0);
    do_req(0, 1, 0, 0); do_req(0, 1, 1, 1); do_req(0, 1, 2, 0);
    do_req(0, 1, 4, 1); do_req(0, 1, 3, 0); do_req(0, 1, 5, 1);
    do_req(0, 1, 7, 0); do_req(0, 1, 6, 1); do_req(0, 1, 8, 0);  // draw
    do_req(1, 0, 0, 0);
    do_req(0, 1, 4, 0); do_req(0, 1, 5, 1); do_req(0, 1, 6, 0);
    do_req(0, 1, 7, 1); do_req(0, 1, 8, 0);

    // Clear with a simultaneous move, cut short by reset in its fifth cycle.
    wait_ready();
    clear_req = 1'b1; move_valid = 1'b1; move_cell = 4'd3;
    @(posedge clock); #1;
    clear_req = 1'b0; move_valid = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    check("clear_we_active", int'(ram_write_enable), 1);
    check("clear_addr", int'(ram_write_address), 4);
    #1 reset_n = 1'b0;
    #1;
    check("async_we_drop", int'(ram_write_enable), 0);
    check("async_resp_valid", int'(resp_valid), 0);
    for (int i = 0; i < 4; i++) model_board[i] = 0;
    model_go = 1'b0;
    @(posedge clock); @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_ready", int'(move_ready), 1);
    check("post_rst_game_over", int'(game_over), 0);
    check_ram();

    for (int n = 0; n < 90; n++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0)      do_req(1, $urandom_range(0, 1) == 1, 0, 0);
      else if (r == 1) do_req(0, 1, int'($urandom_range(9, 15)), $urandom_range(0, 1) == 1);
      else             do_req(0, 1, int'($urandom_range(0, 8)), $urandom_range(0, 1) == 1);
    end

    repeat (5) @(posedge clock);
    #1;
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
